// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - score player that steps ROM entries into the two-channel note generator
module note_sequencer #(
    parameter int BEAT_CYCLES = 12500000,
    parameter int GAP_CYCLES  = 1250000,
    parameter int ADDR_W      = 7,
    parameter int SONG_LEN    = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play,
    input  logic              pause,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [47:0]       mem_data,
    output logic [21:0]       note_div_left,
    output logic [21:0]       note_div_right,
    output logic              playing,
    output logic              song_done,
    output logic              beat_tick
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        PLAY   = 3'd3,
        PAUSED = 3'd4
    } state_t;

    localparam logic [23:0]       BEAT_LAST  = 24'(BEAT_CYCLES - 1);
    localparam logic [23:0]       GAP_START  = 24'(BEAT_CYCLES - GAP_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(SONG_LEN - 1);
    localparam logic [21:0]       DIV_SILENT = 22'd1;

    state_t            state, state_n;
    logic [23:0]       beat_cnt, beat_cnt_n;
    logic [3:0]        beats_left, beats_left_n;
    logic [21:0]       lat_l, lat_l_n;
    logic [21:0]       lat_r, lat_r_n;
    logic [ADDR_W-1:0] addr_n;
    logic [21:0]       div_l_n, div_r_n;
    logic              done_n, tick_n, playing_n, gap_n;
    logic              end_song, abort;

    logic [21:0]       entry_l, entry_r;
    logic [3:0]        entry_dur;
    logic              entry_past;

    assign entry_l    = mem_data[21:0];
    assign entry_r    = mem_data[43:22];
    assign entry_dur  = mem_data[47:44];
    // Only reachable when SONG_LEN is smaller than the address space.
    assign entry_past = ({1'b0, mem_addr} > {1'b0, LAST_ADDR});

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            mem_addr       <= '0;
            beat_cnt       <= '0;
            beats_left     <= '0;
            lat_l          <= DIV_SILENT;
            lat_r          <= DIV_SILENT;
            note_div_left  <= DIV_SILENT;
            note_div_right <= DIV_SILENT;
            playing        <= 1'b0;
            song_done      <= 1'b0;
            beat_tick      <= 1'b0;
        end else begin
            state          <= state_n;
            mem_addr       <= addr_n;
            beat_cnt       <= beat_cnt_n;
            beats_left     <= beats_left_n;
            lat_l          <= lat_l_n;
            lat_r          <= lat_r_n;
            note_div_left  <= div_l_n;
            note_div_right <= div_r_n;
            playing        <= playing_n;
            song_done      <= done_n;
            beat_tick      <= tick_n;
        end
    end

    always_comb begin
        state_n      = state;
        addr_n       = mem_addr;
        beat_cnt_n   = beat_cnt;
        beats_left_n = beats_left;
        lat_l_n      = lat_l;
        lat_r_n      = lat_r;
        done_n       = 1'b0;
        tick_n       = 1'b0;
        end_song     = 1'b0;
        abort        = 1'b0;

        case (state)
            IDLE: begin
                if (play && !stop) begin
                    state_n = FETCH;
                end
            end
            FETCH: begin
                if (stop) begin
                    abort = 1'b1;
                end else begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (stop) begin
                    abort = 1'b1;
                end else if (entry_dur == 4'd0 || entry_past) begin
                    end_song = 1'b1;
                end else begin
                    lat_l_n      = entry_l;
                    lat_r_n      = entry_r;
                    beat_cnt_n   = '0;
                    beats_left_n = entry_dur;
                    state_n      = PLAY;
                end
            end
            PLAY: begin
                if (stop) begin
                    abort = 1'b1;
                end else if (pause) begin
                    // Counters hold this cycle, so a wrap due now stays pending until resume.
                    state_n = PAUSED;
                end else if (beat_cnt == BEAT_LAST) begin
                    tick_n     = 1'b1;
                    beat_cnt_n = '0;
                    if (beats_left <= 4'd1) begin
                        beats_left_n = '0;
                        if (mem_addr == LAST_ADDR) begin
                            end_song = 1'b1;
                        end else begin
                            addr_n  = mem_addr + ADDR_W'(1);
                            state_n = FETCH;
                        end
                    end else begin
                        beats_left_n = beats_left - 4'd1;
                    end
                end else begin
                    beat_cnt_n = beat_cnt + 24'd1;
                end
            end
            PAUSED: begin
                if (stop) begin
                    abort = 1'b1;
                end else if (pause || play) begin
                    state_n = PLAY;
                end
            end
            default: begin
                abort = 1'b1;
            end
        endcase

        if (end_song) begin
            addr_n       = '0;
            beat_cnt_n   = '0;
            beats_left_n = '0;
            if (loop_en) begin
                state_n = FETCH;
            end else begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
        end

        if (abort) begin
            state_n      = IDLE;
            addr_n       = '0;
            beat_cnt_n   = '0;
            beats_left_n = '0;
        end

        // Divs are registered, so they are derived from next-cycle counters:
        // the gap tail of the last beat is silent in the same cycle it is reached.
        gap_n     = (beats_left_n == 4'd1) && (beat_cnt_n >= GAP_START);
        div_l_n   = DIV_SILENT;
        div_r_n   = DIV_SILENT;
        if (state_n == PLAY && !gap_n) begin
            div_l_n = lat_l_n;
            div_r_n = lat_r_n;
        end
        playing_n = (state_n == FETCH) || (state_n == LOAD) || (state_n == PLAY);
    end

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - directed self-checking bench for note_sequencer
module tb_note_sequencer;

    localparam int BEAT_CYCLES = 4;
    localparam int GAP_CYCLES  = 1;
    localparam int ADDR_W      = 3;
    localparam int SONG_LEN    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              play, pause, stop, loop_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [47:0]       mem_data;
    logic [21:0]       note_div_left, note_div_right;
    logic              playing, song_done, beat_tick;

    logic [47:0]       rom [0:7];
    int                n_vec = 0;
    int                n_err = 0;

    note_sequencer #(
        .BEAT_CYCLES(BEAT_CYCLES),
        .GAP_CYCLES (GAP_CYCLES),
        .ADDR_W     (ADDR_W),
        .SONG_LEN   (SONG_LEN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .play          (play),
        .pause         (pause),
        .stop          (stop),
        .loop_en       (loop_en),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .note_div_left (note_div_left),
        .note_div_right(note_div_right),
        .playing       (playing),
        .song_done     (song_done),
        .beat_tick     (beat_tick)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) mem_data <= rom[mem_addr];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] ent(input int l, input int r, input int d);
        return {d[3:0], r[21:0], l[21:0]};
    endfunction

    task automatic load_basic_rom();
        rom[0] = ent(100, 200, 2);
        rom[1] = ent(300, 400, 1);
        rom[2] = 48'd0;
        rom[3] = ent(500, 600, 1);
        for (int i = 4; i < 8; i++) rom[i] = ent(700, 800, 1);
    endtask

    task automatic load_full_rom();
        rom[0] = ent(11, 12, 1);
        rom[1] = ent(1, 22, 1);
        rom[2] = ent(31, 32, 1);
        rom[3] = ent(41, 42, 1);
        for (int i = 4; i < 8; i++) rom[i] = ent(900, 900, 1);
    endtask

    task automatic halt();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        loop_en = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            play    = 1'($urandom_range(0, 1));
            pause   = 1'($urandom_range(0, 1));
            stop    = 1'($urandom_range(0, 1));
            loop_en = 1'($urandom_range(0, 1));
            cyc();
        end
        n_vec++; if (note_div_left !== 22'd1) begin n_err++; $display("FAIL reset div_left: got %0d expected 1", note_div_left); end
        n_vec++; if (note_div_right !== 22'd1) begin n_err++; $display("FAIL reset div_right: got %0d expected 1", note_div_right); end
        n_vec++; if (mem_addr !== 3'd0) begin n_err++; $display("FAIL reset mem_addr: got %0d expected 0", mem_addr); end
        n_vec++; if (playing !== 1'b0) begin n_err++; $display("FAIL reset playing: got %b expected 0", playing); end
        n_vec++; if (song_done !== 1'b0) begin n_err++; $display("FAIL reset song_done: got %b expected 0", song_done); end
        n_vec++; if (beat_tick !== 1'b0) begin n_err++; $display("FAIL reset beat_tick: got %b expected 0", beat_tick); end
        play = 1'b0; pause = 1'b0; stop = 1'b0; loop_en = 1'b0;
        rst = 1'b1;
        cyc();
        n_vec++; if (playing !== 1'b0) begin n_err++; $display("FAIL reset_release playing: got %b expected 0", playing); end
        n_vec++; if (note_div_left !== 22'd1) begin n_err++; $display("FAIL reset_release div_left: got %0d expected 1", note_div_left); end
    endtask

    task automatic test_basic();
        int el, er, ea, et, ed, ep;
        load_basic_rom();
        loop_en = 1'b0;
        play = 1'b1; cyc(); play = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            el = (k >= 3 && k <= 9) ? 100 : (k >= 13 && k <= 15) ? 300 : 1;
            er = (k >= 3 && k <= 9) ? 200 : (k >= 13 && k <= 15) ? 400 : 1;
            ea = (k <= 10) ? 0 : (k <= 16) ? 1 : (k <= 18) ? 2 : 0;
            et = (k == 7 || k == 11 || k == 17) ? 1 : 0;
            ed = (k == 19) ? 1 : 0;
            ep = (k <= 18) ? 1 : 0;
            n_vec++; if (note_div_left !== 22'(el)) begin n_err++; $display("FAIL basic div_left k=%0d: got %0d expected %0d", k, note_div_left, el); end
            n_vec++; if (note_div_right !== 22'(er)) begin n_err++; $display("FAIL basic div_right k=%0d: got %0d expected %0d", k, note_div_right, er); end
            n_vec++; if (mem_addr !== ADDR_W'(ea)) begin n_err++; $display("FAIL basic mem_addr k=%0d: got %0d expected %0d", k, mem_addr, ea); end
            n_vec++; if (beat_tick !== 1'(et)) begin n_err++; $display("FAIL basic beat_tick k=%0d: got %b expected %0d", k, beat_tick, et); end
            n_vec++; if (song_done !== 1'(ed)) begin n_err++; $display("FAIL basic song_done k=%0d: got %b expected %0d", k, song_done, ed); end
            n_vec++; if (playing !== 1'(ep)) begin n_err++; $display("FAIL basic playing k=%0d: got %b expected %0d", k, playing, ep); end
            cyc();
        end
    endtask

    task automatic test_loop_marker();
        int el, ea;
        load_basic_rom();
        loop_en = 1'b1;
        play = 1'b1; cyc(); play = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            el = (k >= 3 && k <= 9) ? 100 : (k >= 13 && k <= 15) ? 300 : (k >= 21) ? 100 : 1;
            ea = (k <= 10) ? 0 : (k <= 16) ? 1 : (k <= 18) ? 2 : 0;
            n_vec++; if (note_div_left !== 22'(el)) begin n_err++; $display("FAIL loop_marker div_left k=%0d: got %0d expected %0d", k, note_div_left, el); end
            n_vec++; if (mem_addr !== ADDR_W'(ea)) begin n_err++; $display("FAIL loop_marker mem_addr k=%0d: got %0d expected %0d", k, mem_addr, ea); end
            n_vec++; if (song_done !== 1'b0) begin n_err++; $display("FAIL loop_marker song_done k=%0d: got %b expected 0", k, song_done); end
            n_vec++; if (playing !== 1'b1) begin n_err++; $display("FAIL loop_marker playing k=%0d: got %b expected 1", k, playing); end
            cyc();
        end
        halt();
    endtask

    task automatic test_full_song(input logic lp);
        int fl[4];
        int fr[4];
        int i, ph, el, er, ea, et, ed, ep;
        fl = '{11, 1, 31, 41};
        fr = '{12, 22, 32, 42};
        load_full_rom();
        loop_en = lp;
        play = 1'b1; cyc(); play = 1'b0;
        for (int k = 1; k <= 27; k++) begin
            i  = ((k - 1) / 6) % 4;
            ph = (k - 1) % 6;
            el = (ph >= 2 && ph <= 4) ? fl[i] : 1;
            er = (ph >= 2 && ph <= 4) ? fr[i] : 1;
            ea = i;
            et = (k >= 7 && ph == 0) ? 1 : 0;
            ed = 0;
            ep = 1;
            if (!lp && k >= 25) begin
                el = 1; er = 1; ea = 0; ep = 0;
                ed = (k == 25) ? 1 : 0;
                et = (k == 25) ? 1 : 0;
            end
            n_vec++; if (note_div_left !== 22'(el)) begin n_err++; $display("FAIL full_song(loop=%b) div_left k=%0d: got %0d expected %0d", lp, k, note_div_left, el); end
            n_vec++; if (note_div_right !== 22'(er)) begin n_err++; $display("FAIL full_song(loop=%b) div_right k=%0d: got %0d expected %0d", lp, k, note_div_right, er); end
            n_vec++; if (mem_addr !== ADDR_W'(ea)) begin n_err++; $display("FAIL full_song(loop=%b) mem_addr k=%0d: got %0d expected %0d", lp, k, mem_addr, ea); end
            n_vec++; if (beat_tick !== 1'(et)) begin n_err++; $display("FAIL full_song(loop=%b) beat_tick k=%0d: got %b expected %0d", lp, k, beat_tick, et); end
            n_vec++; if (song_done !== 1'(ed)) begin n_err++; $display("FAIL full_song(loop=%b) song_done k=%0d: got %b expected %0d", lp, k, song_done, ed); end
            n_vec++; if (playing !== 1'(ep)) begin n_err++; $display("FAIL full_song(loop=%b) playing k=%0d: got %b expected %0d", lp, k, playing, ep); end
            cyc();
        end
        halt();
    endtask

    task automatic test_pause_resume();
        int el, ea, et;
        load_basic_rom();
        loop_en = 1'b0;
        play = 1'b1; cyc(); play = 1'b0;
        for (int k = 1; k < 5; k++) cyc();
        n_vec++; if (note_div_left !== 22'd100) begin n_err++; $display("FAIL pause pre div_left: got %0d expected 100", note_div_left); end
        pause = 1'b1; cyc(); pause = 1'b0;
        for (int j = 0; j < 10; j++) begin
            n_vec++; if (note_div_left !== 22'd1) begin n_err++; $display("FAIL paused div_left j=%0d: got %0d expected 1", j, note_div_left); end
            n_vec++; if (note_div_right !== 22'd1) begin n_err++; $display("FAIL paused div_right j=%0d: got %0d expected 1", j, note_div_right); end
            n_vec++; if (beat_tick !== 1'b0) begin n_err++; $display("FAIL paused beat_tick j=%0d: got %b expected 0", j, beat_tick); end
            n_vec++; if (playing !== 1'b0) begin n_err++; $display("FAIL paused playing j=%0d: got %b expected 0", j, playing); end
            n_vec++; if (mem_addr !== 3'd0) begin n_err++; $display("FAIL paused mem_addr j=%0d: got %0d expected 0", j, mem_addr); end
            if (j == 9) play = 1'b1;
            cyc();
            play = 1'b0;
        end
        for (int k = 16; k <= 22; k++) begin
            el = (k <= 20) ? 100 : 1;
            ea = (k <= 21) ? 0 : 1;
            et = (k == 18 || k == 22) ? 1 : 0;
            n_vec++; if (note_div_left !== 22'(el)) begin n_err++; $display("FAIL resume div_left k=%0d: got %0d expected %0d", k, note_div_left, el); end
            n_vec++; if (mem_addr !== ADDR_W'(ea)) begin n_err++; $display("FAIL resume mem_addr k=%0d: got %0d expected %0d", k, mem_addr, ea); end
            n_vec++; if (beat_tick !== 1'(et)) begin n_err++; $display("FAIL resume beat_tick k=%0d: got %b expected %0d", k, beat_tick, et); end
            n_vec++; if (playing !== 1'b1) begin n_err++; $display("FAIL resume playing k=%0d: got %b expected 1", k, playing); end
            cyc();
        end
        halt();
    endtask

    task automatic test_end_pause();
        load_basic_rom();
        loop_en = 1'b0;
        play = 1'b1; cyc(); play = 1'b0;
        for (int k = 1; k < 10; k++) cyc();
        pause = 1'b1; cyc(); pause = 1'b0;
        for (int j = 0; j < 2; j++) begin
            n_vec++; if (mem_addr !== 3'd0) begin n_err++; $display("FAIL end_pause held mem_addr j=%0d: got %0d expected 0", j, mem_addr); end
            n_vec++; if (playing !== 1'b0) begin n_err++; $display("FAIL end_pause held playing j=%0d: got %b expected 0", j, playing); end
            n_vec++; if (beat_tick !== 1'b0) begin n_err++; $display("FAIL end_pause held beat_tick j=%0d: got %b expected 0", j, beat_tick); end
            n_vec++; if (note_div_left !== 22'd1) begin n_err++; $display("FAIL end_pause held div_left j=%0d: got %0d expected 1", j, note_div_left); end
            if (j == 1) play = 1'b1;
            cyc();
            play = 1'b0;
        end
        n_vec++; if (playing !== 1'b1) begin n_err++; $display("FAIL end_pause resume playing: got %b expected 1", playing); end
        n_vec++; if (note_div_left !== 22'd1) begin n_err++; $display("FAIL end_pause resume gap div_left: got %0d expected 1", note_div_left); end
        n_vec++; if (mem_addr !== 3'd0) begin n_err++; $display("FAIL end_pause resume mem_addr: got %0d expected 0", mem_addr); end
        cyc();
        n_vec++; if (mem_addr !== 3'd1) begin n_err++; $display("FAIL end_pause fetch mem_addr: got %0d expected 1", mem_addr); end
        n_vec++; if (beat_tick !== 1'b1) begin n_err++; $display("FAIL end_pause fetch beat_tick: got %b expected 1", beat_tick); end
        cyc();
        cyc();
        n_vec++; if (note_div_left !== 22'd300) begin n_err++; $display("FAIL end_pause entry2 div_left: got %0d expected 300", note_div_left); end
        n_vec++; if (note_div_right !== 22'd400) begin n_err++; $display("FAIL end_pause entry2 div_right: got %0d expected 400", note_div_right); end
        halt();
    endtask

    task automatic test_stop_priority();
        load_basic_rom();
        loop_en = 1'b0;
        play = 1'b1; cyc(); play = 1'b0;
        for (int k = 1; k < 14; k++) cyc();
        n_vec++; if (mem_addr !== 3'd1) begin n_err++; $display("FAIL stop pre mem_addr: got %0d expected 1", mem_addr); end
        stop = 1'b1; pause = 1'b1; cyc(); stop = 1'b0; pause = 1'b0;
        n_vec++; if (mem_addr !== 3'd0) begin n_err++; $display("FAIL stop mem_addr: got %0d expected 0", mem_addr); end
        n_vec++; if (playing !== 1'b0) begin n_err++; $display("FAIL stop playing: got %b expected 0", playing); end
        n_vec++; if (note_div_left !== 22'd1) begin n_err++; $display("FAIL stop div_left: got %0d expected 1", note_div_left); end
        for (int j = 0; j < 5; j++) begin
            n_vec++; if (song_done !== 1'b0) begin n_err++; $display("FAIL stop song_done j=%0d: got %b expected 0", j, song_done); end
            cyc();
        end
        play = 1'b1; stop = 1'b1; cyc(); play = 1'b0; stop = 1'b0;
        for (int j = 0; j < 3; j++) begin
            n_vec++; if (playing !== 1'b0) begin n_err++; $display("FAIL play_stop idle playing j=%0d: got %b expected 0", j, playing); end
            n_vec++; if (note_div_left !== 22'd1) begin n_err++; $display("FAIL play_stop idle div_left j=%0d: got %0d expected 1", j, note_div_left); end
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        load_basic_rom();
        loop_en = 1'b0;
        play = 1'b1; cyc(); play = 1'b0;
        for (int k = 1; k < 14; k++) cyc();
        rst = 1'b0; cyc(); rst = 1'b1;
        n_vec++; if (mem_addr !== 3'd0) begin n_err++; $display("FAIL reset_mid mem_addr: got %0d expected 0", mem_addr); end
        n_vec++; if (note_div_right !== 22'd1) begin n_err++; $display("FAIL reset_mid div_right: got %0d expected 1", note_div_right); end
        n_vec++; if (playing !== 1'b0) begin n_err++; $display("FAIL reset_mid playing: got %b expected 0", playing); end
        for (int j = 0; j < 3; j++) begin
            n_vec++; if (song_done !== 1'b0) begin n_err++; $display("FAIL reset_mid song_done j=%0d: got %b expected 0", j, song_done); end
            cyc();
        end
    endtask

    initial begin
        play = 1'b0; pause = 1'b0; stop = 1'b0; loop_en = 1'b0; rst = 1'b0;
        load_basic_rom();
        test_reset();
        test_basic();
        test_loop_marker();
        test_full_song(1'b1);
        test_full_song(1'b0);
        test_pause_resume();
        test_end_pause();
        test_stop_priority();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
